// File: rtl/rr_encoder_4to2.sv
// Round-robin 4-to-2 request encoder with a valid/ack handshake.
// The granted code is held until acknowledged; acknowledged grants are counted for debug.
module rr_encoder_4to2 #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic               ack,
  output logic [1:0]         code,
  output logic               valid,
  output logic [1:0]         ptr,
  output logic [COUNT_W-1:0] grant_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         code_nxt;
  logic [1:0]         ptr_nxt;
  logic [COUNT_W-1:0] count_nxt;

  // First set request at or after start, wrapping mod 4; lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      code        <= 2'd0;
      ptr         <= 2'd0;
      grant_count <= '0;
    end else begin
      state       <= state_nxt;
      code        <= code_nxt;
      ptr         <= ptr_nxt;
      grant_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    ptr_nxt   = ptr;
    count_nxt = grant_count;
    case (state)
      IDLE: begin
        if (|req) begin
          code_nxt  = rr_pick(req, ptr);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Requests are ignored while holding; only ack releases the grant.
        if (ack) begin
          state_nxt = IDLE;
          ptr_nxt   = code + 2'd1;
          count_nxt = grant_count + COUNT_W'(1);
        end
      end
    endcase
  end

  assign valid = (state == HOLD);

endmodule

// File: tb/tb_rr_encoder_4to2.sv
// Bench for rr_encoder_4to2: expected grant codes are queued by the stimulus
// and popped by a monitor on each new grant; state registers are checked directly.
module tb_rr_encoder_4to2;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [1:0] code;
  logic       valid;
  logic [1:0] ptr;
  logic [7:0] grant_count;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  rr_encoder_4to2 #(.COUNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .code        (code),
    .valid       (valid),
    .ptr         (ptr),
    .grant_count (grant_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input int v, input int p, input int cnt);
    chk({name, "_valid"}, int'(valid), v);
    chk({name, "_ptr"}, int'(ptr), p);
    chk({name, "_count"}, int'(grant_count), cnt);
  endtask

  // Monitor: every rising valid seen on a falling edge is a new grant.
  initial begin
    logic prev_valid;
    int   exp_code;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", int'(code), -1);
        end else begin
          exp_code = exp_q.pop_front();
          chk("grant_code", int'(code), exp_code);
        end
      end
      prev_valid = valid;
    end
  end

  initial begin
    rst = 1'b0;
    req = 4'b0000;
    ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_state("por", 0, 0, 0);
    chk("por_code", int'(code), 0);
    step(2);
    rst = 1'b0;

    // Single request held through three unacknowledged cycles.
    req = 4'b0100;
    exp_q.push_back(2);
    step(1);
    chk("single_code", int'(code), 2);
    chk("single_valid", int'(valid), 1);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("hold_code", int'(code), 2);
      chk("hold_valid", int'(valid), 1);
    end
    ack = 1'b1;
    step(1);
    chk_state("single_ack", 0, 3, 1);
    ack = 1'b0;

    // Grant from ptr=3, then async reset between edges while holding.
    req = 4'b1111;
    exp_q.push_back(3);
    step(1);
    chk("prerst_code", int'(code), 3);
    chk("prerst_valid", int'(valid), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 0, 0);
    chk("async_rst_code", int'(code), 0);
    step(2);
    chk_state("rst_held", 0, 0, 0);
    chk("rst_held_code", int'(code), 0);
    rst = 1'b0;
    req = 4'b1000;
    exp_q.push_back(3);
    step(1);
    chk("postrst_code", int'(code), 3);
    ack = 1'b1;
    step(1);
    chk_state("postrst_ack", 0, 0, 1);

    // Pointer skip over unrequested positions with ack held high.
    req = 4'b1010;
    exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(1);
    step(1);
    chk("skip1_code", int'(code), 1);
    step(1);
    chk_state("skip1_ack", 0, 2, 2);
    step(1);
    chk("skip2_code", int'(code), 3);
    step(1);
    chk_state("skip2_ack", 0, 0, 3);
    step(1);
    chk("skip3_code", int'(code), 1);
    step(1);
    chk_state("skip3_ack", 0, 2, 4);

    // Fairness: all requesting, ack held; valid alternates every cycle.
    req = 4'b1111;
    for (int j = 0; j < 8; j++) exp_q.push_back((2 + j) % 4);
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("fair_valid", int'(valid), (i % 2 == 0) ? 1 : 0);
    end
    chk_state("fair_end", 0, 2, 12);

    // Counter wrap: 243 more grants reach 255, one more wraps to 0.
    for (int j = 0; j < 243; j++) begin
      exp_q.push_back((2 + j) % 4);
      step(2);
    end
    chk_state("cnt_255", 0, 1, 255);
    exp_q.push_back(1);
    step(1);
    chk("wrap_grant_code", int'(code), 1);
    chk("wrap_grant_count", int'(grant_count), 255);
    step(1);
    chk_state("cnt_wrap", 0, 2, 0);
    chk("wrap_code_held", int'(code), 1);

    req = 4'b0000;
    ack = 1'b0;
    step(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
